ppu_status_nmi: RTL and testbench

- PPU-side producer of the vertical-blank NMI consumed by the CPU interrupt handler. The handler samples ppu_status[7] and latches it until the vector fetch.
- Owns the dot/scanline timing counters, the PPUCTRL NMI-enable bit, the PPUSTATUS register ($2002) with read-to-clear semantics, and the shared $2005/$2006 write toggle.
- Responds to CPU-bus accesses in the $2000-$3FFF window.

---
 rtl/ppu_status_nmi_pkg.sv | 20 ++
 rtl/ppu_dot_counter.sv | 56 +++++
 rtl/ppu_status_nmi.sv | 127 ++++++++++++
 tb/tb_ppu_status_nmi.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_status_nmi_pkg.sv
// Shared register map, status bit layout and address-window decode for the PPU status/NMI block.
// Combinational helpers only, no state and no flow control.
package ppu_status_nmi_pkg;

  localparam logic [2:0] REG_PPUCTRL   = 3'd0;
  localparam logic [2:0] REG_PPUSTATUS = 3'd2;
  localparam logic [2:0] REG_PPUSCROLL = 3'd5;
  localparam logic [2:0] REG_PPUADDR   = 3'd6;

  localparam int STAT_VBL  = 7;
  localparam int STAT_SPR0 = 6;
  localparam int STAT_OVF  = 5;

  localparam logic [2:0] PPU_WINDOW = 3'b001;

  function automatic logic in_window(input logic [15:0] addr);
    return addr[15:13] == PPU_WINDOW;
  endfunction

endpackage

// File: rtl/ppu_dot_counter.sv
// Dot/scanline counters with vblank set and pre-render clear strobes decoded from pre-increment values.
// Advances one dot per dot_en; strobes are combinational from the counter flops and dot_en.
module ppu_dot_counter
  import ppu_status_nmi_pkg::*;
#(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dot_en,
  output logic [8:0] dot,
  output logic [8:0] line,
  output logic       set_evt,
  output logic       clr_evt
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
  localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);

  logic [8:0] dot_q, dot_d;
  logic [8:0] line_q, line_d;

  always_comb begin
    dot_d  = dot_q;
    line_d = line_q;
    if (dot_en) begin
      if (dot_q == DOT_LAST) begin
        dot_d  = 9'd0;
        line_d = (line_q == LINE_LAST) ? 9'd0 : line_q + 9'd1;
      end else begin
        dot_d = dot_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_q  <= 9'd0;
      line_q <= 9'd0;
    end else begin
      dot_q  <= dot_d;
      line_q <= line_d;
    end
  end

  assign dot     = dot_q;
  assign line    = line_q;
  assign set_evt = dot_en && (line_q == VBL_LINE) && (dot_q == 9'd1);
  assign clr_evt = dot_en && (line_q == PRE_LINE) && (dot_q == 9'd1);

endmodule

// File: rtl/ppu_status_nmi.sv
// PPUCTRL/PPUSTATUS registers, shared write toggle and vblank NMI pulse generation for the CPU bus window $2000-$3FFF.
// Read data registered one cycle after cpu_read_en; NMI pulse one cycle after nmi_level rises; no backpressure.
module ppu_status_nmi
  import ppu_status_nmi_pkg::*;
#(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dot_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_data_out,
  input  logic        sprite0_hit_in,
  input  logic        overflow_in,
  output logic [7:0]  ppu_status,
  output logic [8:0]  dot,
  output logic [8:0]  line,
  output logic        w_toggle
);

  logic set_evt, clr_evt;

  ppu_dot_counter #(
    .DOTS_PER_LINE  (DOTS_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME),
    .VBLANK_LINE    (VBLANK_LINE),
    .PRERENDER_LINE (PRERENDER_LINE)
  ) u_dot_counter (
    .clk    (clk),
    .rst    (rst),
    .dot_en (dot_en),
    .dot    (dot),
    .line   (line),
    .set_evt(set_evt),
    .clr_evt(clr_evt)
  );

  // Only the window bits and the mirrored index matter; the rest of the address is don't-care.
  logic unused_addr;
  assign unused_addr = ^cpu_addr[12:3];

  logic       sel, wr_en, rd_en, rd_status;
  logic [2:0] idx;
  assign sel       = in_window(cpu_addr);
  assign idx       = cpu_addr[2:0];
  assign wr_en     = cpu_write_en & sel;
  assign rd_en     = cpu_read_en & sel;
  assign rd_status = rd_en && (idx == REG_PPUSTATUS);

  logic       vblank_q, vblank_d;
  logic       nmi_en_q, nmi_en_d;
  logic       sprite0_q, sprite0_d;
  logic       ovf_q, ovf_d;
  logic [7:0] open_bus_q, open_bus_d;
  logic       w_toggle_q, w_toggle_d;
  logic [7:0] data_out_q, data_out_d;
  logic       nmi_level_q, nmi_level_d;
  logic       nmi_pulse_q, nmi_pulse_d;
  logic [7:0] status_byte;

  always_comb begin
    status_byte            = {3'b000, open_bus_q[4:0]};
    status_byte[STAT_VBL]  = vblank_q;
    status_byte[STAT_SPR0] = sprite0_q;
    status_byte[STAT_OVF]  = ovf_q;

    // A status read on the set edge both returns 0 and keeps vblank low: the race suppresses this frame's NMI.
    if (clr_evt)        vblank_d = 1'b0;
    else if (rd_status) vblank_d = 1'b0;
    else if (set_evt)   vblank_d = 1'b1;
    else                vblank_d = vblank_q;

    sprite0_d = clr_evt ? 1'b0 : (sprite0_q | sprite0_hit_in);
    ovf_d     = clr_evt ? 1'b0 : (ovf_q | overflow_in);

    nmi_en_d   = (wr_en && idx == REG_PPUCTRL) ? cpu_data_in[7] : nmi_en_q;
    open_bus_d = wr_en ? cpu_data_in : open_bus_q;

    w_toggle_d = w_toggle_q;
    if (rd_status)
      w_toggle_d = 1'b0;
    else if (wr_en && (idx == REG_PPUSCROLL || idx == REG_PPUADDR))
      w_toggle_d = ~w_toggle_q;

    data_out_d = data_out_q;
    if (rd_en)
      data_out_d = (idx == REG_PPUSTATUS) ? status_byte : open_bus_q;

    nmi_level_d = vblank_q & nmi_en_q;
    nmi_pulse_d = nmi_level_d & ~nmi_level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank_q    <= 1'b0;
      nmi_en_q    <= 1'b0;
      sprite0_q   <= 1'b0;
      ovf_q       <= 1'b0;
      open_bus_q  <= 8'h00;
      w_toggle_q  <= 1'b0;
      data_out_q  <= 8'h00;
      nmi_level_q <= 1'b0;
      nmi_pulse_q <= 1'b0;
    end else begin
      vblank_q    <= vblank_d;
      nmi_en_q    <= nmi_en_d;
      sprite0_q   <= sprite0_d;
      ovf_q       <= ovf_d;
      open_bus_q  <= open_bus_d;
      w_toggle_q  <= w_toggle_d;
      data_out_q  <= data_out_d;
      nmi_level_q <= nmi_level_d;
      nmi_pulse_q <= nmi_pulse_d;
    end
  end

  assign cpu_data_out = data_out_q;
  assign ppu_status   = {nmi_pulse_q, 7'b0000000};
  assign w_toggle     = w_toggle_q;

endmodule

// File: tb/tb_ppu_status_nmi.sv
// Directed bench for ppu_status_nmi on a shrunken frame (16 dots x 24 lines, vblank line 18, pre-render line 22).
// Read expectations go through a scoreboard queue; NMI pulses are tallied by a monitor.
module tb_ppu_status_nmi;

  localparam int D = 16;
  localparam int L = 24;
  localparam int V = 18;
  localparam int P = 22;

  logic        clk = 1'b0;
  logic        rst;
  logic        dot_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic [7:0]  cpu_data_out;
  logic        sprite0_hit_in;
  logic        overflow_in;
  logic [7:0]  ppu_status;
  logic [8:0]  dot;
  logic [8:0]  line;
  logic        w_toggle;

  ppu_status_nmi #(
    .DOTS_PER_LINE  (D),
    .LINES_PER_FRAME(L),
    .VBLANK_LINE    (V),
    .PRERENDER_LINE (P)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dot_en        (dot_en),
    .cpu_addr      (cpu_addr),
    .cpu_data_in   (cpu_data_in),
    .cpu_write_en  (cpu_write_en),
    .cpu_read_en   (cpu_read_en),
    .cpu_data_out  (cpu_data_out),
    .sprite0_hit_in(sprite0_hit_in),
    .overflow_in   (overflow_in),
    .ppu_status    (ppu_status),
    .dot           (dot),
    .line          (line),
    .w_toggle      (w_toggle)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int m_dot    = 0;
  int m_line   = 0;
  int nmi_rise = 0;
  int nmi_hi   = 0;
  logic nmi_prev = 1'b0;

  always @(negedge clk) begin
    if (ppu_status[7] === 1'b1) nmi_hi++;
    if (ppu_status[7] === 1'b1 && nmi_prev !== 1'b1) nmi_rise++;
    nmi_prev = ppu_status[7];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (dot_en && !rst) begin
      if (m_dot == D - 1) begin
        m_dot  = 0;
        m_line = (m_line == L - 1) ? 0 : m_line + 1;
      end else begin
        m_dot = m_dot + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int tl, input int td);
    for (int i = 0; i < 4 * D * L && !(m_line == tl && m_dot == td); i++) tick();
    check("run_to_line", 16'(line), 16'(tl));
    check("run_to_dot", 16'(dot), 16'(td));
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr     = a;
    cpu_data_in  = d;
    cpu_write_en = 1'b1;
    tick();
    cpu_write_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    cpu_addr    = a;
    cpu_read_en = 1'b1;
    sb_q.push_back(e);
    tick();
    cpu_read_en = 1'b0;
    e = sb_q.pop_front();
    check(e.tag, 16'(cpu_data_out), 16'(e.val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    dot_en         = 1'b0;
    cpu_addr       = 16'h0000;
    cpu_data_in    = 8'h00;
    cpu_write_en   = 1'b0;
    cpu_read_en    = 1'b0;
    sprite0_hit_in = 1'b0;
    overflow_in    = 1'b0;

    @(negedge clk);
    check("rst_dot", 16'(dot), 16'd0);
    check("rst_line", 16'(line), 16'd0);
    check("rst_status", 16'(ppu_status), 16'h00);
    check("rst_data_out", 16'(cpu_data_out), 16'h00);
    check("rst_w_toggle", 16'(w_toggle), 16'd0);

    rst    = 1'b0;
    dot_en = 1'b1;
    m_dot  = 0;
    m_line = 0;

    // Frame 1: NMI enabled, vblank pulse.
    cpu_write(16'h2000, 8'h80);
    run_to(V, 1);
    check("nmi_before_set", 16'(nmi_rise), 16'd0);
    tick();
    check("nmi_not_yet", 16'(ppu_status), 16'h00);
    tick();
    check("nmi_pulse", 16'(ppu_status), 16'h80);
    tick();
    check("nmi_one_cycle", 16'(ppu_status), 16'h00);
    check("nmi_count_f1", 16'(nmi_rise), 16'd1);

    cpu_write(16'h2005, 8'h13);
    check("w_toggle_set", 16'(w_toggle), 16'd1);
    cpu_read(16'h2002, 8'h93, "status_vbl");
    check("w_toggle_cleared", 16'(w_toggle), 16'd0);
    cpu_read(16'h2002, 8'h13, "status_second");
    cpu_read(16'h3FFF, 8'h13, "mirror_open_bus");

    cpu_write(16'h4000, 8'hFF);
    cpu_addr    = 16'h4002;
    cpu_read_en = 1'b1;
    tick();
    cpu_read_en = 1'b0;
    check("oob_read_hold", 16'(cpu_data_out), 16'h13);
    cpu_read(16'h2007, 8'h13, "oob_write_ignored");

    // Frame 2: sticky sprite0/overflow, late enable and re-toggle pulses.
    run_to(0, 3);
    cpu_write(16'h2000, 8'h00);
    run_to(3, 5);
    sprite0_hit_in = 1'b1;
    tick();
    sprite0_hit_in = 1'b0;
    cpu_read(16'h2002, 8'h40, "spr0_set");
    cpu_read(16'h2002, 8'h40, "spr0_sticky");
    overflow_in = 1'b1;
    tick();
    overflow_in = 1'b0;
    cpu_read(16'h200A, 8'h60, "ovf_set");

    run_to(V, 1);
    tick();
    tick();
    tick();
    check("no_nmi_disabled", 16'(nmi_rise), 16'd1);

    run_to(V + 1, 0);
    cpu_write(16'h2000, 8'h80);
    check("late_en_not_yet", 16'(ppu_status), 16'h00);
    tick();
    check("late_en_pulse", 16'(ppu_status), 16'h80);
    tick();
    check("late_en_one_cycle", 16'(ppu_status), 16'h00);
    check("nmi_count_late", 16'(nmi_rise), 16'd2);

    cpu_write(16'h2000, 8'h00);
    cpu_write(16'h2000, 8'h80);
    tick();
    tick();
    check("nmi_retoggle", 16'(nmi_rise), 16'd3);
    check("nmi_widths", 16'(nmi_hi), 16'd3);

    cpu_write(16'h2000, 8'h00);
    run_to(P, 1);
    cpu_addr       = 16'h2000;
    cpu_data_in    = 8'h80;
    cpu_write_en   = 1'b1;
    sprite0_hit_in = 1'b1;
    tick();
    cpu_write_en   = 1'b0;
    sprite0_hit_in = 1'b0;
    tick();
    tick();
    tick();
    check("clear_vs_enable", 16'(nmi_rise), 16'd3);
    cpu_read(16'h2002, 8'h00, "clear_wins");

    // Frame 3: status read racing the set event.
    run_to(V, 1);
    cpu_read(16'h200A, 8'h00, "race_read");
    run_to(V + 2, 0);
    cpu_read(16'h2002, 8'h00, "race_vbl_stays0");
    run_to(1, 0);
    check("race_no_nmi", 16'(nmi_rise), 16'd3);
    check("race_no_pulse_hi", 16'(nmi_hi), 16'd3);

    dot_en = 1'b0;
    repeat (5) tick();
    check("hold_dot", 16'(dot), 16'd0);
    check("hold_line", 16'(line), 16'd1);
    dot_en = 1'b1;

    // Asynchronous mid-frame reset.
    cpu_write(16'h2006, 8'h5A);
    check("w_toggle_2006", 16'(w_toggle), 16'd1);
    cpu_read(16'h2001, 8'h5A, "open_bus_read");
    run_to(10, 9);
    #2 rst = 1'b1;
    #1;
    check("arst_dot", 16'(dot), 16'd0);
    check("arst_line", 16'(line), 16'd0);
    check("arst_status", 16'(ppu_status), 16'h00);
    check("arst_data_out", 16'(cpu_data_out), 16'h00);
    check("arst_w_toggle", 16'(w_toggle), 16'd0);
    @(negedge clk);
    rst    = 1'b0;
    m_dot  = 0;
    m_line = 0;
    tick();
    tick();
    tick();
    check("resume_dot", 16'(dot), 16'd3);
    check("resume_line", 16'(line), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
